// File: rtl/pmu_pkg.sv
// Constants and state encoding shared by the pmu key-frame transmitter and the pmu receiver.
package pmu_pkg;

  localparam int HEADER_WIDTH   = 32;
  localparam int AES_DATA_WIDTH = 128;
  localparam int FRAME_W        = HEADER_WIDTH + AES_DATA_WIDTH;
  localparam int WAIT_CYCLES    = 130;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } pmu_state_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register: parallel load, right shift with zero fill, LSB is the serial output.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ser_o
);

  logic [WIDTH-1:0] shift_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
    end else if (shift_i) begin
      shift_q <= {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  assign ser_o = shift_q[0];

endmodule

// File: rtl/pmu_key_tx.sv
// Serial key-frame transmitter for the pmu load interface: frame LSB-first with en,
// one zero guard bit, then a bounded wait for pwr_up_en with a pass/timeout report.
module pmu_key_tx #(
  parameter int HEADER_WIDTH   = pmu_pkg::HEADER_WIDTH,
  parameter int AES_DATA_WIDTH = pmu_pkg::AES_DATA_WIDTH,
  parameter int WAIT_CYCLES    = pmu_pkg::WAIT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [HEADER_WIDTH+AES_DATA_WIDTH-1:0] frame_i,
  output logic                                   busy_o,
  output logic                                   data_o,
  output logic                                   en_o,
  input  logic                                   pwr_up_en_i,
  output logic                                   done_o,
  output logic                                   ok_o
);

  import pmu_pkg::*;

  localparam int FRAME_LEN = HEADER_WIDTH + AES_DATA_WIDTH;
  localparam int BIT_CW    = cnt_width(FRAME_LEN);
  localparam int WAIT_CW   = cnt_width(WAIT_CYCLES);

  localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(FRAME_LEN - 1);
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(WAIT_CYCLES - 1);

  pmu_state_e         state_q;
  logic [BIT_CW-1:0]  bit_cnt_q;
  logic [WAIT_CW-1:0] wait_cnt_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic               ok_q;

  logic               load_d;
  logic               shift_d;

  assign load_d  = (state_q == IDLE) && start_i;
  assign shift_d = (state_q == SEND);

  // The shifter zero-fills, so data_o is already 0 in GUARD, WAIT and IDLE.
  piso_shift #(
    .WIDTH (FRAME_LEN)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_d),
    .shift_i (shift_d),
    .data_i  (frame_i),
    .ser_o   (data_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q   <= SEND;
            bit_cnt_q <= '0;
            en_q      <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        SEND: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_q <= GUARD;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        GUARD: begin
          state_q    <= WAIT;
          en_q       <= 1'b0;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          // Feedback on the final count cycle still reports success.
          if (pwr_up_en_i) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ok_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign en_o   = en_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ok_o   = ok_q;

endmodule
